// File: rtl/beat_timing_controller.sv
// Multi-channel beat/note timing: phase-accumulator sixteenth-note tick plus per-channel note FSMs.
// Optional DOTTED_EN: mode 11 plays dotted notes (D + D/2); otherwise mode 11 equals mode 10.
module beat_timing_controller #(
  parameter int CHANNELS = 4,
  parameter int BPM_W    = 8,
  parameter int ACC_W    = 32,
  parameter int TICK_INC = 23
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [BPM_W-1:0]        BPM,
  input  logic [2*CHANNELS-1:0]   MODE,
  input  logic [4*CHANNELS-1:0]   NOTE,
  output logic                    TICK,
  output logic                    BEAT,
  output logic [CHANNELS-1:0]     EN,
  output logic [CHANNELS-1:0]     BUSY,
  output logic [CHANNELS-1:0]     DONE
);

  // state    | meaning
  // IDLE     | channel off
  // ARMED    | enabled, waiting for the next tick to start a note
  // PLAY     | note counting down on ticks
  // FINISHED | one-shot note complete, DONE held until mode goes off
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLAY, S_FINISHED} ch_state_t;

`ifdef DOTTED_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  localparam logic [ACC_W:0] INC = (ACC_W+1)'(TICK_INC);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_step;
  logic [ACC_W:0]   acc_sum;
  logic [3:0]       tick_idx;
  logic             tick_q;

  ch_state_t        state_q [CHANNELS];
  ch_state_t        state_d [CHANNELS];
  logic [CNT_W-1:0] count_q [CHANNELS];
  logic [CNT_W-1:0] count_d [CHANNELS];
  logic [CHANNELS-1:0] rep_q, rep_d;
  logic [CHANNELS-1:0] en_q, en_d;

  // Carry out of the accumulator is the tick; no divider needed for the tempo.
  assign acc_step = (ACC_W+1)'(BPM) * INC;
  assign acc_sum  = {1'b0, acc} + acc_step;

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc      <= '0;
      tick_q   <= 1'b0;
      tick_idx <= '0;
    end else begin
      acc    <= acc_sum[ACC_W-1:0];
      tick_q <= acc_sum[ACC_W];
      if (tick_q) tick_idx <= tick_idx + 4'd1;
    end
  end

  assign TICK = tick_q;
  assign BEAT = tick_q && (tick_idx == 4'd0);

  always_comb begin
    logic [1:0]       cur_mode;
    logic [3:0]       cur_note;
    logic [CNT_W-1:0] load_val;
`ifdef DOTTED_EN
    logic [4:0]       dur;
    dur = '0;
`endif
    cur_mode = '0;
    cur_note = '0;
    load_val = '0;
    rep_d    = rep_q;
    en_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      cur_mode   = MODE[2*i +: 2];
      cur_note   = NOTE[4*i +: 4];
`ifdef DOTTED_EN
      dur = {1'b0, cur_note} + 5'd1;
      if (cur_mode == 2'b11) dur = dur + (dur >> 1);
      load_val = dur - 5'd1;
`else
      load_val = cur_note;
`endif
      if (cur_mode == 2'b00) begin
        state_d[i] = S_IDLE;
        count_d[i] = '0;
      end else begin
        case (state_q[i])
          S_IDLE: state_d[i] = S_ARMED;
          S_ARMED: begin
            if (tick_q) begin
              rep_d[i]   = cur_mode[1];
              count_d[i] = load_val;
              en_d[i]    = 1'b1;
              state_d[i] = S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick_q) begin
              if (count_q[i] != '0) begin
                count_d[i] = count_q[i] - 1'b1;
              end else if (rep_q[i]) begin
                // Note boundary: pick up whatever MODE/NOTE is current now.
                rep_d[i]   = cur_mode[1];
                count_d[i] = load_val;
                en_d[i]    = 1'b1;
              end else begin
                state_d[i] = S_FINISHED;
              end
            end
          end
          default: state_d[i] = S_FINISHED;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rep_q <= '0;
      en_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        count_q[i] <= '0;
      end
    end else begin
      rep_q <= rep_d;
      en_q  <= en_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  always_comb begin
    BUSY = '0;
    DONE = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      BUSY[i] = (state_q[i] == S_ARMED) || (state_q[i] == S_PLAY);
      DONE[i] = (state_q[i] == S_FINISHED);
    end
  end

  assign EN = en_q;

endmodule

// File: tb/tb_beat_timing_controller.sv
// Directed bench for beat_timing_controller (2 channels, 8-bit accumulator, TICK_INC=1).
// Expected dotted-note period follows DOTTED_EN.
module tb_beat_timing_controller;

  logic       clk;
  logic       rst;
  logic [7:0] bpm;
  logic [3:0] mode;
  logic [7:0] note;
  logic       tick, beat;
  logic [1:0] en, busy, done;

  int compared;
  int mismatched;

  beat_timing_controller #(
    .CHANNELS(2), .BPM_W(8), .ACC_W(8), .TICK_INC(1)
  ) dut (
    .CLK(clk), .RST(rst), .BPM(bpm), .MODE(mode), .NOTE(note),
    .TICK(tick), .BEAT(beat), .EN(en), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this, the n-th step() samples the cycle following the n-th edge after release.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    bpm = 8'd64; mode = 4'b1010; note = 8'h33;
    rst = 1'b1;
    step();
    step();
    got = {tick, beat, en, busy, done};
    compared++;
    if (got !== 8'h00) begin
      mismatched++;
      $display("FAIL reset outputs got %b want %b", got, 8'h00);
    end
    rst = 1'b0;
  endtask

  task automatic test_tick_beat();
    logic [7:0] got, exp;
    bpm = 8'd64; mode = 4'b0000; note = 8'h00;
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      step();
      got = {tick, beat, en, busy, done};
      exp = {(n % 4 == 0), (n == 4 || n == 68), 6'b000000};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL tick_beat n=%0d got %b want %b", n, got, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic [7:0] got, exp;
    bpm = 8'd64; mode = 4'b0010; note = 8'h03;
    do_reset();
    for (int n = 1; n <= 60; n++) begin
      step();
      got = {tick, beat, en, busy, done};
      exp = {(n % 4 == 0), (n == 4), 1'b0, (n >= 5 && (n - 5) % 16 == 0), 2'b01, 2'b00};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL repeat n=%0d got %b want %b", n, got, exp);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] got, exp;
    bpm = 8'd64; mode = 4'b0100; note = 8'h70;
    do_reset();
    for (int n = 1; n <= 50; n++) begin
      step();
      got = {tick, beat, en, busy, done};
      exp = {(n % 4 == 0), (n == 4), (n == 5), 1'b0, (n <= 36), 1'b0, (n >= 37), 1'b0};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL oneshot n=%0d got %b want %b", n, got, exp);
      end
    end
    mode = 4'b0000;
    step();
    got = {tick, beat, en, busy, done};
    compared++;
    if (got !== 8'h00) begin
      mismatched++;
      $display("FAIL oneshot_clear got %b want %b", got, 8'h00);
    end
  endtask

  task automatic test_dotted();
    logic [7:0] got, exp;
    int period;
`ifdef DOTTED_EN
    period = 24;
`else
    period = 16;
`endif
    bpm = 8'd64; mode = 4'b0011; note = 8'h03;
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      step();
      got = {tick, beat, en, busy, done};
      exp = {(n % 4 == 0), (n == 4 || n == 68), 1'b0, (n >= 5 && (n - 5) % period == 0),
             2'b01, 2'b00};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL dotted n=%0d got %b want %b", n, got, exp);
      end
    end
  endtask

  task automatic test_freeze();
    logic [7:0] got, exp;
    logic       t;
    bpm = 8'd64; mode = 4'b0001; note = 8'h07;
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      if (n == 15) bpm = 8'd0;
      if (n == 65) bpm = 8'd64;
      step();
      t = (n <= 14 && n % 4 == 0) || (n >= 66 && (n - 66) % 4 == 0);
      got = {tick, beat, en, busy, done};
      exp = {t, (n == 4), 1'b0, (n == 5), 1'b0, (n <= 86), 1'b0, (n >= 87)};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL freeze n=%0d got %b want %b", n, got, exp);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] got, exp;
    bpm = 8'd64; mode = 4'b0010; note = 8'h03;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      step();
      got = {tick, beat, en, busy, done};
      exp = {(n % 4 == 0), (n == 4), 1'b0, (n == 5), 2'b01, 2'b00};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL rst_mid_pre n=%0d got %b want %b", n, got, exp);
      end
    end
    rst = 1'b1;
    step();
    got = {tick, beat, en, busy, done};
    compared++;
    if (got !== 8'h00) begin
      mismatched++;
      $display("FAIL rst_mid got %b want %b", got, 8'h00);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    logic       b;
    bpm = 8'd128; mode = 4'b0000; note = 8'h10;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) mode = 4'b1010;
      step();
      b = (n >= 3);
      got = {tick, beat, en, busy, done};
      exp = {(n % 2 == 0), (n == 2), (n >= 5 && (n - 5) % 4 == 0), (n >= 5 && n % 2 == 1),
             b, b, 2'b00};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL back_to_back n=%0d got %b want %b", n, got, exp);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst  = 1'b1;
    bpm  = 8'd0;
    mode = 4'b0000;
    note = 8'h00;
    test_reset();
    test_tick_beat();
    test_repeat();
    test_oneshot();
    test_dotted();
    test_freeze();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
